// File: rtl/ser_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and default word width.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int unsigned SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/ser_bit_cnt.sv
// Bit position counter for ser_tx: clears on word load, advances per shifted bit,
// saturates at WIDTH-1 and flags that final position.
module ser_bit_cnt
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST_CNT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter, MSB first, with framing and a done pulse on the
// last bit; a new word may be accepted on the last bit for gapless streaming.
module ser_tx
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             done
);

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic             last;
    logic             accept;
    logic             cnt_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode only state, counter and shift_reg flops; in_ready is gated by
    // rst so a word presented at release is taken on the very first edge.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ser_out   = 1'b0;
        ser_frame = 1'b0;
        done      = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
            end
            SHIFT: begin
                ser_out   = shift_reg[WIDTH-1];
                ser_frame = 1'b1;
                done      = last;
                in_ready  = last & ~rst;
                cnt_en    = ~last;
            end
        endcase
        accept = in_valid & in_ready;
        if (accept) begin
            state_nxt = SHIFT;
        end else if ((state == SHIFT) && last) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= data_in;
        end else if (state == SHIFT) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        end
    end

    ser_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (cnt_en),
        .last (last)
    );

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx: directed scenarios plus random traffic, checked against a
// queue of pending serial bits derived from the accepted words.
module tb_ser_tx;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_frame;
    logic             done;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          done_cnt     = 0;
    logic [31:0] rx           = '0;
    bit          exp_q[$];

    ser_tx #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_frame (ser_frame),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle, entered just after a falling edge: drive, check, step the model.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
        bit acc;
        in_valid = v;
        data_in  = d;
        #1;
        check("ser_out",   ser_out,   (exp_q.size() > 0) ? exp_q[0] : 1'b0);
        check("ser_frame", ser_frame, exp_q.size() > 0);
        check("done",      done,      exp_q.size() == 1);
        check("in_ready",  in_ready,  exp_q.size() <= 1);
        if (ser_frame) rx = {rx[30:0], ser_out};
        if (done) done_cnt++;
        acc = v && (exp_q.size() <= 1);
        @(posedge clk);
        if (acc) begin
            exp_q.delete();
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        cyc++;
    endtask

    // Assert rst between edges, hold it across one rising edge, release on a falling edge.
    task automatic async_reset(input logic v, input logic [WIDTH-1:0] d);
        #2 rst = 1'b1;
        #1;
        check("rst_ser_out",   ser_out,   1'b0);
        check("rst_ser_frame", ser_frame, 1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_in_ready",  in_ready,  1'b0);
        exp_q.delete();
        in_valid = v;
        data_in  = d;
        @(negedge clk);
        check("rst_hold_ready", in_ready, 1'b0);
        check("rst_hold_frame", ser_frame, 1'b0);
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        logic [31:0] r;

        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        #2;
        check("reset_ser_out",   ser_out,   1'b0);
        check("reset_ser_frame", ser_frame, 1'b0);
        check("reset_done",      done,      1'b0);
        check("reset_in_ready",  in_ready,  1'b0);
        @(negedge clk);
        check("reset_hold_ready", in_ready, 1'b0);
        rst = 1'b0;

        // Single word
        rx = '0; done_cnt = 0;
        cycle(1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
        check("single_word", rx, 32'h0000_00A5);
        check("single_done", done_cnt, 1);

        // Back-to-back with in_valid held high
        rx = '0; done_cnt = 0;
        cycle(1'b1, 8'hFF);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'h77);
        cycle(1'b0, 8'h77);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
        check("b2b_stream", rx, 32'h0000_FF00);
        check("b2b_done", done_cnt, 2);

        // Stall: in_valid toggling with other data while shifting
        rx = '0; done_cnt = 0;
        cycle(1'b1, 8'h81);
        for (int i = 0; i < 7; i++) cycle(1'(i % 2), 8'h3C);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h3C);
        check("stall_word", rx, 32'h0000_0081);
        check("stall_done", done_cnt, 1);

        // Idle gap after a word
        rx = '0; done_cnt = 0;
        cycle(1'b1, 8'h55);
        for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00);
        check("gap_word", rx, 32'h0000_0055);

        // Async reset during bit 4, then a clean word
        rx = '0; done_cnt = 0;
        cycle(1'b1, 8'hC3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
        async_reset(1'b0, 8'h00);
        check("abort_no_done", done_cnt, 0);
        rx = '0;
        cycle(1'b1, 8'h01);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
        check("after_abort_word", rx, 32'h0000_0001);
        check("after_abort_done", done_cnt, 1);

        // Release reset with a word already presented
        rx = '0; done_cnt = 0;
        async_reset(1'b1, 8'h80);
        cycle(1'b1, 8'h80);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00);
        check("post_reset_word", rx, 32'h0000_0080);
        check("post_reset_done", done_cnt, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            cycle(($urandom_range(0, 3) != 0), r[WIDTH-1:0]);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
